time_min_hour_counter: RTL and testbench

//   Downstream stage of the seconds counter in the digital clock. Consumes the

---
 rtl/time_min_hour_counter.sv | 122 ++++++++++++
 tb/tb_time_min_hour_counter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_min_hour_counter.sv
// Minutes/hours stage of the digital clock: counts seconds-wrap ticks, supports
// a button-driven time-set mode and drives binary plus BCD digits to the display.
module time_min_hour_counter #(
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       min_tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       day_pulse,
    output logic [1:0] set_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10
    } state_e;

    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX);
    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);

    state_e     state_q, state_d;
    logic [5:0] min_q, min_d;
    logic [4:0] hour_q, hour_d;
    logic [7:0] min_bcd_q, min_bcd_d;
    logic [7:0] hour_bcd_q, hour_bcd_d;
    logic       day_q, day_d;

    function automatic logic [7:0] to_bcd(input logic [6:0] value);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(value / 7'd10);
        units = 4'(value % 7'd10);
        return {tens, units};
    endfunction

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = 1'b0;

        case (state_q)
            ST_RUN: begin
                // The tick is applied even when mode_btn arrives in the same cycle.
                if (min_tick) begin
                    if (min_q >= MIN_LAST) begin
                        min_d = '0;
                        if (hour_q >= HOUR_LAST) begin
                            hour_d = '0;
                            day_d  = 1'b1;
                        end else begin
                            hour_d = hour_q + 5'd1;
                        end
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end
                if (mode_btn) begin
                    state_d = ST_SET_HOUR;
                end
            end

            ST_SET_HOUR: begin
                if (mode_btn) begin
                    state_d = ST_SET_MIN;
                end else if (inc_btn) begin
                    hour_d = (hour_q >= HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
                end
            end

            ST_SET_MIN: begin
                if (mode_btn) begin
                    state_d = ST_RUN;
                end else if (inc_btn) begin
                    min_d = (min_q >= MIN_LAST) ? 6'd0 : min_q + 6'd1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Digits derive from the next-state value so they never lag the binary.
        min_bcd_d  = to_bcd({1'b0, min_d});
        hour_bcd_d = to_bcd({2'b00, hour_d});
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            min_q      <= '0;
            hour_q     <= '0;
            min_bcd_q  <= '0;
            hour_bcd_q <= '0;
            day_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            min_bcd_q  <= min_bcd_d;
            hour_bcd_q <= hour_bcd_d;
            day_q      <= day_d;
        end
    end

    assign minutes   = min_q;
    assign hours     = hour_q;
    assign min_bcd   = min_bcd_q;
    assign hour_bcd  = hour_bcd_q;
    assign day_pulse = day_q;
    assign set_state = state_q;

endmodule

// File: tb/tb_time_min_hour_counter.sv
// Self-checking bench for time_min_hour_counter: scoreboard of expected
// outputs from a total-minutes reference model plus directed scenario checks.
module tb_time_min_hour_counter;

    logic       clock;
    logic       reset_n;
    logic       min_tick;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [7:0] min_bcd;
    logic [7:0] hour_bcd;
    logic       day_pulse;
    logic [1:0] set_state;

    time_min_hour_counter #(.MIN_MAX(59), .HOUR_MAX(23)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .min_tick  (min_tick),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .minutes   (minutes),
        .hours     (hours),
        .min_bcd   (min_bcd),
        .hour_bcd  (hour_bcd),
        .day_pulse (day_pulse),
        .set_state (set_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] m;
        logic [4:0] h;
        logic [7:0] mb;
        logic [7:0] hb;
        logic       dp;
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference model state
    int m_min  = 0;
    int m_hour = 0;
    int m_st   = 0;
    int m_dp   = 0;

    function automatic logic [7:0] bcd_ref(input int value);
        int t;
        int v;
        logic [7:0] r;
        t = 0;
        v = value;
        while (v >= 10) begin
            v = v - 10;
            t = t + 1;
        end
        r[7:4] = 4'(t);
        r[3:0] = 4'(v);
        return r;
    endfunction

    task automatic model_apply(input logic tk, input logic md, input logic ic);
        int total;
        m_dp = 0;
        case (m_st)
            0: begin
                if (tk) begin
                    total = m_hour * 60 + m_min + 1;
                    if (total == 24 * 60) begin
                        total = 0;
                        m_dp  = 1;
                    end
                    m_hour = total / 60;
                    m_min  = total % 60;
                end
                if (md) m_st = 1;
            end
            1: begin
                if (md) m_st = 2;
                else if (ic) m_hour = (m_hour + 1) % 24;
            end
            default: begin
                if (md) m_st = 0;
                else if (ic) m_min = (m_min + 1) % 60;
            end
        endcase
    endtask

    task automatic model_reset();
        m_min  = 0;
        m_hour = 0;
        m_st   = 0;
        m_dp   = 0;
    endtask

    // One cycle of stimulus; the expected outputs go on the scoreboard.
    task automatic step(input logic tk, input logic md, input logic ic);
        exp_t e;
        @(negedge clock);
        min_tick = tk;
        mode_btn = md;
        inc_btn  = ic;
        model_apply(tk, md, ic);
        e.m  = 6'(m_min);
        e.h  = 5'(m_hour);
        e.mb = bcd_ref(m_min);
        e.hb = bcd_ref(m_hour);
        e.dp = (m_dp != 0);
        e.st = 2'(m_st);
        sb_q.push_back(e);
        @(posedge clock);
        #2;
        min_tick = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    // From RUN, load hh:mm through the set mode and return to RUN.
    task automatic preset(input int h, input int m);
        step(1'b0, 1'b1, 1'b0);
        while (m_hour != h) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        while (m_min != m) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        preset(12, 34);
        vectors++;
        if ({hours, minutes} !== {5'd12, 6'd34}) begin
            miscompares++;
            $display("FAIL preset_1234 got %0d:%0d want 12:34", hours, minutes);
        end
        #1;
        reset_n = 1'b0;
        #1;
        sb_q.delete();
        model_reset();
        vectors++;
        if ({minutes, hours, min_bcd, hour_bcd, day_pulse, set_state} !== 29'd0) begin
            miscompares++;
            $display("FAIL async_reset got m=%0d h=%0d mb=%h hb=%h dp=%b st=%b want all 0",
                     minutes, hours, min_bcd, hour_bcd, day_pulse, set_state);
        end
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        vectors++;
        if (minutes !== 6'd1 || min_bcd !== 8'h01) begin
            miscompares++;
            $display("FAIL reset_first_tick got m=%0d mb=%h want 1/01", minutes, min_bcd);
        end
        $display("test_reset done");
    endtask

    task automatic test_minute_wrap();
        preset(5, 59);
        step(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({hours, minutes, hour_bcd, min_bcd, day_pulse} !== {5'd6, 6'd0, 8'h06, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL minute_wrap got %0d:%0d hb=%h mb=%h dp=%b want 6:0 06 00 0",
                     hours, minutes, hour_bcd, min_bcd, day_pulse);
        end
        $display("test_minute_wrap done");
    endtask

    task automatic test_day_wrap();
        preset(23, 59);
        step(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({hours, minutes, day_pulse} !== {5'd0, 6'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL day_wrap got %0d:%0d dp=%b want 0:0 dp=1", hours, minutes, day_pulse);
        end
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (day_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL day_pulse_width got %b want 0", day_pulse);
        end
        $display("test_day_wrap done");
    endtask

    task automatic test_set_mode();
        logic [4:0] want_h [3];
        want_h[0] = 5'd23;
        want_h[1] = 5'd0;
        want_h[2] = 5'd1;
        preset(22, 59);
        step(1'b0, 1'b1, 1'b0);
        vectors++;
        if (set_state !== 2'b01) begin
            miscompares++;
            $display("FAIL enter_set_hour got %b want 01", set_state);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            vectors++;
            if (hours !== want_h[i] || day_pulse !== 1'b0) begin
                miscompares++;
                $display("FAIL set_hour_inc%0d got h=%0d dp=%b want %0d/0", i, hours, day_pulse, want_h[i]);
            end
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        vectors++;
        if ({set_state, hours, minutes} !== {2'b10, 5'd1, 6'd0}) begin
            miscompares++;
            $display("FAIL set_min_wrap got st=%b %0d:%0d want 10 1:0", set_state, hours, minutes);
        end
        step(1'b1, 1'b0, 1'b0);
        vectors++;
        if ({hours, minutes} !== {5'd1, 6'd0}) begin
            miscompares++;
            $display("FAIL tick_in_set_min got %0d:%0d want 1:0", hours, minutes);
        end
        step(1'b0, 1'b1, 1'b0);
        $display("test_set_mode done");
    endtask

    task automatic test_collisions();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        vectors++;
        if (set_state !== 2'b10 || hours !== 5'd1) begin
            miscompares++;
            $display("FAIL mode_inc_collision got st=%b h=%0d want 10 h=1", set_state, hours);
        end
        step(1'b1, 1'b1, 1'b0);
        vectors++;
        if (set_state !== 2'b00 || minutes !== 6'd0) begin
            miscompares++;
            $display("FAIL mode_tick_set_min got st=%b m=%0d want 00 m=0", set_state, minutes);
        end
        preset(10, 10);
        step(1'b1, 1'b1, 1'b0);
        vectors++;
        if ({hours, minutes, set_state} !== {5'd10, 6'd11, 2'b01}) begin
            miscompares++;
            $display("FAIL mode_tick_run got %0d:%0d st=%b want 10:11 01", hours, minutes, set_state);
        end
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        $display("test_collisions done");
    endtask

    task automatic test_random();
        logic tk, md, ic;
        for (int i = 0; i < 10000; i++) begin
            tk = ($urandom_range(0, 2) == 0);
            md = ($urandom_range(0, 15) == 0);
            ic = ($urandom_range(0, 3) == 0);
            step(tk, md, ic);
            vectors++;
            if (minutes > 6'd59 || hours > 5'd23) begin
                miscompares++;
                $display("FAIL range cycle %0d got %0d:%0d want <=23:59", i, hours, minutes);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        reset_n  = 1'b0;
        min_tick = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;

        fork
            forever begin
                exp_t e;
                @(posedge clock);
                #1;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    vectors++;
                    if ({minutes, hours, min_bcd, hour_bcd, day_pulse, set_state} !==
                        {e.m, e.h, e.mb, e.hb, e.dp, e.st}) begin
                        miscompares++;
                        $display("FAIL scoreboard got m=%0d h=%0d mb=%h hb=%h dp=%b st=%b want m=%0d h=%0d mb=%h hb=%h dp=%b st=%b",
                                 minutes, hours, min_bcd, hour_bcd, day_pulse, set_state,
                                 e.m, e.h, e.mb, e.hb, e.dp, e.st);
                    end
                end
            end
            begin
                #2000000;
                $display("FAIL watchdog timeout got no finish want finish before 2ms");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if ({minutes, hours, min_bcd, hour_bcd, day_pulse, set_state} !== 29'd0) begin
            miscompares++;
            $display("FAIL power_on_reset got m=%0d h=%0d st=%b want 0", minutes, hours, set_state);
        end
        @(negedge clock);
        reset_n = 1'b1;

        test_reset();
        test_minute_wrap();
        test_day_wrap();
        test_set_mode();
        test_collisions();
        test_random();

        repeat (3) @(posedge clock);
        #2;
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
